// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one trial subtraction per clock,
// start/done handshake, divide-by-zero flagged with an all-ones quotient.
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q;
    logic [CW-1:0]    count_q;
    // The partial remainder never exceeds B-1, so its top bit is always zero
    // and only the low WIDTH bits are stored.
    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] r_q;
    logic             dbz_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH:0]   shifted_d;
    logic [WIDTH:0]   trial_d;
    logic             qbit_d;
    logic [WIDTH-1:0] p_d;
    logic [WIDTH-1:0] d_d;

    always_comb begin
        shifted_d = {p_q, d_q[WIDTH-1]};
        trial_d   = shifted_d - {1'b0, b_q};
        qbit_d    = ~trial_d[WIDTH];
        p_d       = qbit_d ? trial_d[WIDTH-1:0] : shifted_d[WIDTH-1:0];
        d_d       = {d_q[WIDTH-2:0], qbit_d};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            p_q     <= '0;
            d_q     <= '0;
            b_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        b_q <= B;
                        d_q <= A;
                        p_q <= '0;
                        if (B != '0) begin
                            state_q <= S_RUN;
                            count_q <= CW'(WIDTH);
                            q_q     <= '0;
                            r_q     <= '0;
                            dbz_q   <= 1'b0;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end else begin
                            state_q <= S_DONE;
                            q_q     <= '1;
                            r_q     <= A;
                            dbz_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                S_RUN: begin
                    p_q     <= p_d;
                    d_q     <= d_d;
                    count_q <= count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        state_q <= S_DONE;
                        q_q     <= d_d;
                        r_q     <= p_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign Q           = q_q;
    assign R           = r_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=4): hand-computed results, latency,
// back-to-back, ignored start, reset abort and an exhaustive invariant sweep.
module tb_seq_divider;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic       busy;
    logic       done;
    logic [3:0] Q;
    logic [3:0] R;
    logic       div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .Q           (Q),
        .R           (R),
        .div_by_zero (div_by_zero)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Launches one division; latency counts edges from the capture edge (=1)
    // to the edge after which done is observed. Samples are taken #1 after edges.
    task automatic do_div(input logic [3:0] a, input logic [3:0] b, input bit sync,
                          output int lat, output int busy_cycles);
        if (sync) @(negedge clk);
        A = a;
        B = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 1;
        busy_cycles = busy ? 1 : 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) busy_cycles++;
        end
        if (!done) check_eq("done_timeout", 0, 1);
    endtask

    int lat;
    int bc;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        A = '0;
        B = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_Q", Q, 0);
        check_eq("rst_R", R, 0);
        check_eq("rst_dbz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 13 / 3
        do_div(4'd13, 4'd3, 1'b1, lat, bc);
        check_eq("t1_lat", lat, 5);
        check_eq("t1_busy", bc, 4);
        check_eq("t1_Q", Q, 4);
        check_eq("t1_R", R, 1);
        check_eq("t1_dbz", div_by_zero, 0);
        @(posedge clk);
        #1;
        check_eq("t1_done_pulse", done, 0);
        check_eq("t1_Q_hold", Q, 4);
        check_eq("t1_R_hold", R, 1);
        $display("txn 13/3 lat=%0d Q=%0d R=%0d", lat, Q, R);

        do_div(4'd15, 4'd1, 1'b1, lat, bc);
        check_eq("t2a_lat", lat, 5);
        check_eq("t2a_Q", Q, 15);
        check_eq("t2a_R", R, 0);
        $display("txn 15/1 lat=%0d Q=%0d R=%0d", lat, Q, R);

        do_div(4'd0, 4'd5, 1'b1, lat, bc);
        check_eq("t2b_lat", lat, 5);
        check_eq("t2b_Q", Q, 0);
        check_eq("t2b_R", R, 0);
        $display("txn 0/5 lat=%0d Q=%0d R=%0d", lat, Q, R);

        // Divide by zero
        do_div(4'd7, 4'd0, 1'b1, lat, bc);
        check_eq("t3_lat", lat, 1);
        check_eq("t3_busy", bc, 0);
        check_eq("t3_Q", Q, 15);
        check_eq("t3_R", R, 7);
        check_eq("t3_dbz", div_by_zero, 1);
        $display("txn 7/0 lat=%0d Q=%0d R=%0d dbz=%0d", lat, Q, R, div_by_zero);

        // 3 / 9, then back-to-back start issued during DONE
        do_div(4'd3, 4'd9, 1'b1, lat, bc);
        check_eq("t4a_Q", Q, 0);
        check_eq("t4a_R", R, 3);
        check_eq("t4a_dbz", div_by_zero, 0);
        do_div(4'd12, 4'd4, 1'b0, lat, bc);
        check_eq("t4b_lat", lat, 5);
        check_eq("t4b_Q", Q, 3);
        check_eq("t4b_R", R, 0);
        $display("txn 12/4 back-to-back lat=%0d Q=%0d R=%0d", lat, Q, R);
        @(posedge clk);
        #1;
        check_eq("t4b_done_pulse", done, 0);

        // start held with changing operands during RUN is ignored
        @(negedge clk);
        A = 4'd13;
        B = 4'd3;
        start = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            A = 4'(lat * 5 + 2);
            B = 4'(lat + 6);
        end while (!done && lat < 20);
        start = 1'b0;
        check_eq("t5_lat", lat, 5);
        check_eq("t5_Q", Q, 4);
        check_eq("t5_R", R, 1);
        $display("txn 13/3 with start held lat=%0d Q=%0d R=%0d", lat, Q, R);
        @(posedge clk);
        #1;

        // Reset abort in the second RUN cycle
        @(negedge clk);
        A = 4'd14;
        B = 4'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("t6_busy_run", busy, 1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("t6_busy", busy, 0);
        check_eq("t6_done", done, 0);
        check_eq("t6_Q", Q, 0);
        check_eq("t6_R", R, 0);
        check_eq("t6_dbz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("t6_idle_done", done, 0);
        do_div(4'd14, 4'd5, 1'b1, lat, bc);
        check_eq("t6_lat", lat, 5);
        check_eq("t6_Q_fresh", Q, 2);
        check_eq("t6_R_fresh", R, 4);
        $display("txn 14/5 after reset lat=%0d Q=%0d R=%0d", lat, Q, R);

        // Exhaustive sweep
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_div(4'(a), 4'(b), 1'b1, lat, bc);
                if (b == 0) begin
                    check_eq("sw_dbz_Q", Q, 15);
                    check_eq("sw_dbz_R", R, a);
                    check_eq("sw_dbz_flag", div_by_zero, 1);
                end else begin
                    check_eq("sw_identity", int'(Q) * b + int'(R), a);
                    check_eq("sw_r_lt_b", (int'(R) < b) ? 1 : 0, 1);
                    check_eq("sw_lat", lat, 5);
                end
            end
        end
        $display("txn sweep 16x16 complete");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
